// File: rtl/sample_reconstructor_if.sv
// Stream bundle around the sample reconstructor: timestamp input,
// discriminated data input and the reconstructed output stream.
interface sample_reconstructor_if #(
   parameter int SAMPLE_WIDTH       = 16,
   parameter int PARALLEL_SAMPLES   = 4,
   parameter int SAMPLE_INDEX_WIDTH = 14,
   parameter int CLOCK_WIDTH        = 50
);
   localparam int W = SAMPLE_WIDTH * PARALLEL_SAMPLES;

   logic [SAMPLE_INDEX_WIDTH+CLOCK_WIDTH-1:0] ts_data;
   logic                                      ts_valid;
   logic                                      ts_ready;

   logic [W-1:0]                              data_in_data;
   logic                                      data_in_valid;
   logic                                      data_in_ready;

   logic [W-1:0]                              data_out_data;
   logic                                      data_out_valid;
   logic                                      data_out_ready;
   logic                                      data_out_fill;
   logic [CLOCK_WIDTH-1:0]                    data_out_time;

   // Reconstructor side: consumes timestamps and data, produces the stream
   modport slave (
      input  ts_data, ts_valid,
      output ts_ready,
      input  data_in_data, data_in_valid,
      output data_in_ready,
      output data_out_data, data_out_valid, data_out_fill, data_out_time,
      input  data_out_ready
   );

   // Environment side: produces timestamps and data, sinks the stream
   modport master (
      output ts_data, ts_valid,
      input  ts_ready,
      output data_in_data, data_in_valid,
      input  data_in_ready,
      input  data_out_data, data_out_valid, data_out_fill, data_out_time,
      output data_out_ready
   );
endinterface

// File: rtl/sample_reconstructor.sv
// Rebuilds a time-aligned sample stream from discriminated data words and
// their segment-start timestamps by re-inserting zero fill words, so that
// output word t always corresponds to discriminator timer value t.
module sample_reconstructor #(
   parameter int SAMPLE_WIDTH       = 16,
   parameter int PARALLEL_SAMPLES   = 4,
   parameter int SAMPLE_INDEX_WIDTH = 14,
   parameter int CLOCK_WIDTH        = 50
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_reset_state,
   sample_reconstructor_if.slave bus,
   output logic                  o_error_ts_order,
   output logic                  o_error_index
);
   localparam int W = SAMPLE_WIDTH * PARALLEL_SAMPLES;
   localparam logic [CLOCK_WIDTH-1:0]        TIME_ONE  = {{(CLOCK_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [SAMPLE_INDEX_WIDTH-1:0] INDEX_ONE = {{(SAMPLE_INDEX_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE,
      GAP,
      BURST
   } state_t;

   state_t                        r_state;
   state_t                        w_next_state;
   logic                          r_active;
   logic [CLOCK_WIDTH-1:0]        r_out_time;
   logic [CLOCK_WIDTH-1:0]        r_target;
   logic [SAMPLE_INDEX_WIDTH-1:0] r_data_index;
   logic                          r_err_ts_order;
   logic                          r_err_index;

   logic [W-1:0]                  r_q_data;
   logic                          r_q_valid;
   logic                          r_q_fill;
   logic [CLOCK_WIDTH-1:0]        r_q_time;

   logic [CLOCK_WIDTH-1:0]        w_ts_timer;
   logic [SAMPLE_INDEX_WIDTH-1:0] w_ts_index;
   logic                          w_out_free;
   logic                          w_ts_ready;
   logic                          w_data_in_ready;
   logic                          w_ts_accept;
   logic                          w_data_accept;
   logic                          w_fill_load;

   assign w_ts_timer = bus.ts_data[SAMPLE_INDEX_WIDTH +: CLOCK_WIDTH];
   assign w_ts_index = bus.ts_data[0 +: SAMPLE_INDEX_WIDTH];
   assign w_out_free = !r_q_valid || bus.data_out_ready;

   // Next-state and handshake decode; readies stay low in reset, on the
   // first cycle after reset and while a state clear is pending, so no
   // handshake can complete that the state clear would silently drop.
   always_comb begin
      w_next_state    = r_state;
      w_ts_ready      = 1'b0;
      w_data_in_ready = 1'b0;
      w_ts_accept     = 1'b0;
      w_data_accept   = 1'b0;
      w_fill_load     = 1'b0;
      if (r_active && !i_reset_state) begin
         case (r_state)
            IDLE: begin
               w_ts_ready  = 1'b1;
               w_ts_accept = bus.ts_valid;
            end
            GAP: begin
               if (r_out_time != r_target) begin
                  w_fill_load = w_out_free;
               end else begin
                  w_next_state = BURST;
               end
            end
            BURST: begin
               if (bus.ts_valid && (w_ts_index == r_data_index)) begin
                  w_ts_ready  = 1'b1;
                  w_ts_accept = 1'b1;
               end else begin
                  w_data_in_ready = w_out_free;
                  w_data_accept   = w_out_free && bus.data_in_valid;
               end
            end
            default: begin
               w_next_state = IDLE;
            end
         endcase
         if (w_ts_accept) begin
            w_next_state = (w_ts_timer > r_out_time) ? GAP : BURST;
         end
      end
   end

   // State, counters, target and sticky error flags; a late timestamp
   // rewinds out_time so the following data is tagged with its own timer.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state        <= IDLE;
         r_active       <= 1'b0;
         r_out_time     <= '0;
         r_target       <= '0;
         r_data_index   <= '0;
         r_err_ts_order <= 1'b0;
         r_err_index    <= 1'b0;
      end else if (i_reset_state) begin
         r_state        <= IDLE;
         r_active       <= 1'b1;
         r_out_time     <= '0;
         r_target       <= '0;
         r_data_index   <= '0;
         r_err_ts_order <= 1'b0;
         r_err_index    <= 1'b0;
      end else begin
         r_state  <= w_next_state;
         r_active <= 1'b1;
         if (w_ts_accept) begin
            r_target <= w_ts_timer;
            if (w_ts_timer < r_out_time) begin
               r_err_ts_order <= 1'b1;
               r_out_time     <= w_ts_timer;
            end
            if ((r_state == IDLE) && (w_ts_index != r_data_index)) begin
               r_err_index  <= 1'b1;
               r_data_index <= w_ts_index;
            end
         end
         if (w_fill_load || w_data_accept) begin
            r_out_time <= r_out_time + TIME_ONE;
         end
         if (w_data_accept) begin
            r_data_index <= r_data_index + INDEX_ONE;
         end
      end
   end

   // Single output register stage: loads a fill or data word when free,
   // otherwise holds its contents until the sink takes them.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_q_data  <= '0;
         r_q_valid <= 1'b0;
         r_q_fill  <= 1'b0;
         r_q_time  <= '0;
      end else if (i_reset_state) begin
         r_q_data  <= '0;
         r_q_valid <= 1'b0;
         r_q_fill  <= 1'b0;
         r_q_time  <= '0;
      end else if (w_fill_load) begin
         r_q_data  <= '0;
         r_q_valid <= 1'b1;
         r_q_fill  <= 1'b1;
         r_q_time  <= r_out_time;
      end else if (w_data_accept) begin
         r_q_data  <= bus.data_in_data;
         r_q_valid <= 1'b1;
         r_q_fill  <= 1'b0;
         r_q_time  <= r_out_time;
      end else if (bus.data_out_ready) begin
         r_q_valid <= 1'b0;
      end
   end

   assign bus.ts_ready       = w_ts_ready;
   assign bus.data_in_ready  = w_data_in_ready;
   assign bus.data_out_data  = r_q_data;
   assign bus.data_out_valid = r_q_valid;
   assign bus.data_out_fill  = r_q_fill;
   assign bus.data_out_time  = r_q_time;
   assign o_error_ts_order   = r_err_ts_order;
   assign o_error_index      = r_err_index;
endmodule

// File: tb/tb_sample_reconstructor.sv
// Self-checking bench for sample_reconstructor: expected output words are
// listed by hand per scenario, plus a small segment model for random runs.
module tb_sample_reconstructor;
   localparam int SW  = 16;
   localparam int PS  = 4;
   localparam int SIW = 14;
   localparam int CW  = 50;
   localparam int W   = SW * PS;

   localparam logic [W-1:0] DA  = 64'h0A0A_0001_0002_0003;
   localparam logic [W-1:0] DB  = 64'h0B0B_0004_0005_0006;
   localparam logic [W-1:0] DC  = 64'h0C0C_0007_0008_0009;
   localparam logic [W-1:0] DE  = 64'h0E0E_1111_2222_3333;
   localparam logic [W-1:0] DF  = 64'h0F0F_4444_5555_6666;
   localparam logic [W-1:0] DG  = 64'h1234_5678_9ABC_DEF0;
   localparam logic [W-1:0] DH  = 64'h7777_0000_7777_0001;
   localparam logic [W-1:0] DH2 = 64'h7777_0000_7777_0002;
   localparam logic [W-1:0] DI  = 64'h9999_AAAA_BBBB_0001;
   localparam logic [W-1:0] DJ  = 64'h9999_AAAA_BBBB_0002;
   localparam logic [W-1:0] DK  = 64'h9999_AAAA_BBBB_0003;
   localparam logic [W-1:0] DX  = 64'hDEAD_BEEF_CAFE_F00D;

   typedef struct {
      logic          fill;
      logic [CW-1:0] tm;
      logic [W-1:0]  data;
   } word_t;

   typedef struct {
      bit             isTs;
      logic [CW-1:0]  timer;
      logic [SIW-1:0] idx;
      logic [W-1:0]   data;
   } op_t;

   logic clk = 1'b0;
   logic rst_n;
   logic resetState;
   logic errTs;
   logic errIdx;

   int checks = 0;
   int errors = 0;

   word_t got[$];
   word_t expQ[$];

   bit   randReady   = 1'b0;
   logic readyForce  = 1'b1;
   bit   held        = 1'b0;
   word_t heldW;

   sample_reconstructor_if #(
      .SAMPLE_WIDTH(SW), .PARALLEL_SAMPLES(PS),
      .SAMPLE_INDEX_WIDTH(SIW), .CLOCK_WIDTH(CW)
   ) bus ();

   sample_reconstructor #(
      .SAMPLE_WIDTH(SW), .PARALLEL_SAMPLES(PS),
      .SAMPLE_INDEX_WIDTH(SIW), .CLOCK_WIDTH(CW)
   ) dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .i_reset_state    (resetState),
      .bus              (bus.slave),
      .o_error_ts_order (errTs),
      .o_error_index    (errIdx)
   );

   // Free-running 100 MHz clock
   always #5 clk = ~clk;

   // Sink ready: either forced by the test or randomized at 50%
   always @(posedge clk) begin
      #1;
      bus.data_out_ready = randReady ? 1'($urandom_range(0, 1)) : readyForce;
   end

   // Output monitor: records every transferred word and checks that a
   // stalled word stays put until it is taken
   always @(negedge clk) begin
      if (rst_n && !resetState) begin
         if (held) begin
            checks++;
            if (!bus.data_out_valid || bus.data_out_fill !== heldW.fill ||
                bus.data_out_time !== heldW.tm || bus.data_out_data !== heldW.data) begin
               errors++;
               $display("[TB] FAIL holdStable actual=%0b/%0h/%0h required=1/%0h/%0h",
                        bus.data_out_valid, bus.data_out_time, bus.data_out_data,
                        heldW.tm, heldW.data);
            end
         end
         heldW.fill = bus.data_out_fill;
         heldW.tm   = bus.data_out_time;
         heldW.data = bus.data_out_data;
         if (bus.data_out_valid && bus.data_out_ready) begin
            got.push_back(heldW);
         end
         held = bus.data_out_valid && !bus.data_out_ready;
      end else begin
         held = 1'b0;
      end
   end

   // Watchdog so the bench can never hang
   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkVal(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic void expFill(input longint t);
      word_t w;
      w.fill = 1'b1;
      w.tm   = CW'(t);
      w.data = '0;
      expQ.push_back(w);
   endfunction

   function automatic void expData(input longint t, input logic [W-1:0] d);
      word_t w;
      w.fill = 1'b0;
      w.tm   = CW'(t);
      w.data = d;
      expQ.push_back(w);
   endfunction

   // Drive one timestamp or data word through its handshake, with an
   // optional random idle gap before it
   task automatic applyStimulus(input op_t op, input int gapMax, output longint acceptTime);
      bit done;
      done = 1'b0;
      acceptTime = 0;
      repeat ($urandom_range(0, gapMax)) @(posedge clk);
      @(posedge clk);
      #1;
      if (op.isTs) begin
         bus.ts_data  = {op.timer, op.idx};
         bus.ts_valid = 1'b1;
      end else begin
         bus.data_in_data  = op.data;
         bus.data_in_valid = 1'b1;
      end
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (op.isTs ? bus.ts_ready : bus.data_in_ready) begin
            done = 1'b1;
            acceptTime = longint'($time);
            @(posedge clk);
            #1;
         end
      end
      if (op.isTs) bus.ts_valid = 1'b0;
      else         bus.data_in_valid = 1'b0;
      checkVal(op.isTs ? "tsHandshake" : "dataHandshake", 128'(done), 128'd1);
   endtask

   task automatic sendTs(input longint timer, input int idx, input int gapMax);
      op_t op;
      longint t;
      op.isTs  = 1'b1;
      op.timer = CW'(timer);
      op.idx   = SIW'(idx);
      op.data  = '0;
      applyStimulus(op, gapMax, t);
   endtask

   task automatic sendData(input logic [W-1:0] d, input int gapMax);
      op_t op;
      longint t;
      op.isTs  = 1'b0;
      op.timer = '0;
      op.idx   = '0;
      op.data  = d;
      applyStimulus(op, gapMax, t);
   endtask

   // Wait (bounded) for all expected words, then compare them in order
   task automatic checkOutput(input string name);
      int n;
      for (int i = 0; i < 400 && got.size() < expQ.size(); i++) @(negedge clk);
      repeat (5) @(negedge clk);
      checkVal({name, "_count"}, 128'(got.size()), 128'(expQ.size()));
      n = (got.size() < expQ.size()) ? got.size() : expQ.size();
      for (int i = 0; i < n; i++) begin
         checkVal($sformatf("%s_word%0d", name, i),
                  {13'd0, got[i].fill, got[i].tm, got[i].data},
                  {13'd0, expQ[i].fill, expQ[i].tm, expQ[i].data});
      end
      got.delete();
      expQ.delete();
   endtask

   task automatic doStateReset();
      @(posedge clk);
      #1;
      resetState = 1'b1;
      @(posedge clk);
      #1;
      resetState = 1'b0;
   endtask

   // First two test-plan scenarios; the second timestamp races data C
   task automatic runScenario(input int gapMax);
      op_t tsOp;
      op_t cOp;
      longint tTs;
      longint tC;
      sendTs(3, 0, gapMax);
      sendData(DA, gapMax);
      sendData(DB, gapMax);
      tsOp.isTs = 1'b1; tsOp.timer = CW'(8); tsOp.idx = SIW'(2); tsOp.data = '0;
      cOp.isTs  = 1'b0; cOp.timer = '0;      cOp.idx = '0;       cOp.data = DC;
      if (gapMax == 0) begin
         fork
            applyStimulus(tsOp, 0, tTs);
            applyStimulus(cOp, 0, tC);
         join
      end else begin
         applyStimulus(tsOp, gapMax, tTs);
         applyStimulus(cOp, gapMax, tC);
      end
      checkVal("dataAfterTs", 128'(tC > tTs), 128'd1);
   endtask

   initial begin
      automatic longint outT;
      automatic int     dIdx;
      automatic int     gap;
      automatic int     nWords;
      automatic logic [W-1:0] d;

      rst_n             = 1'b0;
      resetState        = 1'b0;
      bus.ts_valid      = 1'b0;
      bus.ts_data       = '0;
      bus.data_in_valid = 1'b0;
      bus.data_in_data  = '0;

      // Reset values
      #12;
      checkVal("rstTsReady",    128'(bus.ts_ready), 128'd0);
      checkVal("rstDataReady",  128'(bus.data_in_ready), 128'd0);
      checkVal("rstOutValid",   128'(bus.data_out_valid), 128'd0);
      checkVal("rstOutTime",    128'(bus.data_out_time), 128'd0);
      checkVal("rstErrors",     128'({errTs, errIdx}), 128'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checkVal("idleTsReady", 128'(bus.ts_ready), 128'd1);

      // Scenario: gap fill then data, ready always high
      expFill(0); expFill(1); expFill(2); expData(3, DA); expData(4, DB);
      expFill(5); expFill(6); expFill(7); expData(8, DC);
      runScenario(0);
      checkOutput("scenA");
      checkVal("scenAErrors", 128'({errTs, errIdx}), 128'd0);

      // Same scenario with random backpressure and gapped valids
      doStateReset();
      randReady = 1'b1;
      expFill(0); expFill(1); expFill(2); expData(3, DA); expData(4, DB);
      expFill(5); expFill(6); expFill(7); expData(8, DC);
      runScenario(3);
      checkOutput("scenB");
      checkVal("scenBErrors", 128'({errTs, errIdx}), 128'd0);

      // Late timestamp rewinds time; timer equal to out_time adds no fill
      randReady  = 1'b0;
      readyForce = 1'b1;
      sendTs(2, 3, 0);
      checkVal("tsOrderFlag", 128'(errTs), 128'd1);
      sendData(DE, 0);
      sendTs(3, 4, 0);
      sendData(DF, 0);
      expData(2, DE); expData(3, DF);
      checkOutput("tsOrderBoundary");
      checkVal("tsOrderSticky", 128'({errTs, errIdx}), 128'b10);

      // State clear mid-gap while a fill word is held
      readyForce = 1'b0;
      sendTs(20, 5, 0);
      repeat (3) @(negedge clk);
      checkVal("gapHeldValid", 128'({bus.data_out_valid, bus.data_out_fill}), 128'b11);
      checkVal("gapHeldTime", 128'(bus.data_out_time), 128'd4);
      doStateReset();
      checkVal("clrValid", 128'(bus.data_out_valid), 128'd0);
      checkVal("clrErrors", 128'({errTs, errIdx}), 128'd0);
      readyForce = 1'b1;
      sendTs(1, 0, 0);
      sendData(DG, 0);
      expFill(0); expData(1, DG);
      checkOutput("afterStateReset");

      // Index mismatch in IDLE adopts the timestamp index
      doStateReset();
      sendTs(0, 5, 0);
      checkVal("indexFlag", 128'({errTs, errIdx}), 128'b01);
      sendData(DH, 0);
      sendTs(1, 6, 0);
      sendData(DH2, 0);
      expData(0, DH); expData(1, DH2);
      checkOutput("indexAdopt");
      checkVal("indexSticky", 128'(errIdx), 128'd1);

      // data_index wrap from 16383 to 0, then a boundary on index 0
      doStateReset();
      sendTs(0, 16382, 0);
      sendData(DI, 0);
      sendData(DJ, 0);
      sendTs(4, 0, 0);
      sendData(DK, 0);
      expData(0, DI); expData(1, DJ); expFill(2); expFill(3); expData(4, DK);
      checkOutput("indexWrap");

      // Random segments against a simple timeline model
      doStateReset();
      randReady = 1'b1;
      outT = 0;
      dIdx = 0;
      for (int s = 0; s < 6; s++) begin
         gap = $urandom_range(0, 4);
         sendTs(outT + gap, dIdx, 2);
         for (int k = 0; k < gap; k++) begin
            expFill(outT);
            outT++;
         end
         nWords = $urandom_range(1, 4);
         for (int k = 0; k < nWords; k++) begin
            d = {$urandom, $urandom};
            sendData(d, 2);
            expData(outT, d);
            outT++;
            dIdx = (dIdx + 1) % (1 << SIW);
         end
      end
      checkOutput("randomSegments");
      checkVal("randomErrors", 128'({errTs, errIdx}), 128'd0);

      // Asynchronous reset mid-burst with a word held in the output
      randReady  = 1'b0;
      readyForce = 1'b0;
      repeat (2) @(posedge clk);
      sendData(DX, 0);
      @(negedge clk);
      checkVal("preRstValid", 128'(bus.data_out_valid), 128'd1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkVal("asyncValid", 128'(bus.data_out_valid), 128'd0);
      checkVal("asyncData",  128'(bus.data_out_data), 128'd0);
      checkVal("asyncTime",  128'({bus.data_out_time, bus.data_out_fill}), 128'd0);
      checkVal("asyncReady", 128'({bus.ts_ready, bus.data_in_ready}), 128'd0);
      checkVal("asyncErrors", 128'({errTs, errIdx}), 128'd0);
      repeat (2) @(posedge clk);
      rst_n = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
